// File: rtl/mc_ctrl_pkg.sv
// Shared types and encodings for the multi-cycle control sequencer.
package mc_ctrl_pkg;

  localparam int WORD_SIZE = 16;

  // Sequencer states; the encoding is also visible on the debug port.
  typedef enum logic [3:0] {
    S_RST,
    S_IF,
    S_ID,
    S_EX_R,
    S_EX_I,
    S_EX_ADDR,
    S_MEM_RD,
    S_MEM_WR,
    S_WB_ALU,
    S_WB_MEM,
    S_EX_BR,
    S_EX_J,
    S_EX_WWD,
    S_HALT
  } state_t;

  // Instruction classes produced by the decoder.
  typedef enum logic [2:0] {
    CL_NOP,
    CL_RALU,
    CL_IALU,
    CL_MEM,
    CL_BR,
    CL_JUMP,
    CL_WWD,
    CL_HLT
  } inst_class_t;

  // Opcodes (instruction[15:12])
  localparam logic [3:0] OP_BNE   = 4'd0;
  localparam logic [3:0] OP_BEQ   = 4'd1;
  localparam logic [3:0] OP_BGZ   = 4'd2;
  localparam logic [3:0] OP_BLZ   = 4'd3;
  localparam logic [3:0] OP_ADI   = 4'd4;
  localparam logic [3:0] OP_ORI   = 4'd5;
  localparam logic [3:0] OP_LHI   = 4'd6;
  localparam logic [3:0] OP_LWD   = 4'd7;
  localparam logic [3:0] OP_SWD   = 4'd8;
  localparam logic [3:0] OP_JMP   = 4'd9;
  localparam logic [3:0] OP_JAL   = 4'd10;
  localparam logic [3:0] OP_RTYPE = 4'd15;

  // Function codes (instruction[5:0]) under OP_RTYPE; 0..7 are ALU ops.
  localparam logic [5:0] FN_ALU_MAX = 6'd7;
  localparam logic [5:0] FN_JPR     = 6'd25;
  localparam logic [5:0] FN_JRL     = 6'd26;
  localparam logic [5:0] FN_WWD     = 6'd28;
  localparam logic [5:0] FN_HLT     = 6'd29;

  // pc_src
  localparam logic [1:0] PC_SRC_ALU    = 2'd0;
  localparam logic [1:0] PC_SRC_ALUOUT = 2'd1;
  localparam logic [1:0] PC_SRC_JTGT   = 2'd2;
  localparam logic [1:0] PC_SRC_RS     = 2'd3;

  // reg_dst
  localparam logic [1:0] REG_DST_RT = 2'd0;
  localparam logic [1:0] REG_DST_RD = 2'd1;
  localparam logic [1:0] REG_DST_R2 = 2'd2;

  // wb_sel
  localparam logic [1:0] WB_ALUOUT = 2'd0;
  localparam logic [1:0] WB_MDR    = 2'd1;
  localparam logic [1:0] WB_PC     = 2'd2;

  // alu_src_a
  localparam logic ALU_A_PC = 1'b0;
  localparam logic ALU_A_RS = 1'b1;

  // alu_src_b
  localparam logic [1:0] ALU_B_RT   = 2'd0;
  localparam logic [1:0] ALU_B_ONE  = 2'd1;
  localparam logic [1:0] ALU_B_SEXT = 2'd2;
  localparam logic [1:0] ALU_B_ZEXT = 2'd3;

  // alu_op
  localparam logic [1:0] ALU_OP_ADD   = 2'd0;
  localparam logic [1:0] ALU_OP_CMP   = 2'd1;
  localparam logic [1:0] ALU_OP_RFUNC = 2'd2;
  localparam logic [1:0] ALU_OP_IFUNC = 2'd3;

endpackage

// File: rtl/mc_ctrl_decode.sv
// Combinational instruction classifier: opcode/func to class plus the
// per-instruction flags the sequencer needs in its execute/write-back states.
module mc_ctrl_decode
  import mc_ctrl_pkg::*;
(
  input  logic [3:0]  opcode,
  input  logic [5:0]  func,
  output inst_class_t inst_class,
  output logic        is_link,
  output logic        is_reg_jump,
  output logic        is_ori,
  output logic        is_rtype,
  output logic        is_load
);

  // Classify the instruction; unrecognised encodings fall through to NOP.
  always_comb begin
    inst_class  = CL_NOP;
    is_link     = 1'b0;
    is_reg_jump = 1'b0;
    is_ori      = (opcode == OP_ORI);
    is_rtype    = (opcode == OP_RTYPE);
    is_load     = (opcode == OP_LWD);
    case (opcode)
      OP_BNE, OP_BEQ, OP_BGZ, OP_BLZ: inst_class = CL_BR;
      OP_ADI, OP_ORI, OP_LHI:         inst_class = CL_IALU;
      OP_LWD, OP_SWD:                 inst_class = CL_MEM;
      OP_JMP:                         inst_class = CL_JUMP;
      OP_JAL: begin
        inst_class = CL_JUMP;
        is_link    = 1'b1;
      end
      OP_RTYPE: begin
        if (func <= FN_ALU_MAX) begin
          inst_class = CL_RALU;
        end else begin
          case (func)
            FN_JPR: begin
              inst_class  = CL_JUMP;
              is_reg_jump = 1'b1;
            end
            FN_JRL: begin
              inst_class  = CL_JUMP;
              is_reg_jump = 1'b1;
              is_link     = 1'b1;
            end
            FN_WWD:  inst_class = CL_WWD;
            FN_HLT:  inst_class = CL_HLT;
            default: inst_class = CL_NOP;
          endcase
        end
      end
      default: inst_class = CL_NOP;
    endcase
  end

endmodule

// File: rtl/mc_control_fsm.sv
// Multi-cycle control sequencer: steps the shared datapath through
// fetch/decode/execute/memory/write-back and counts committed instructions.
//
// Handshake: there is no valid/ready pair. pvs_write_en is a one-cycle
// commit strobe asserted in an instruction's last cycle; opcode/func are
// expected stable from the cycle after ir_write until the next fetch.
module mc_control_fsm
  import mc_ctrl_pkg::*;
(
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic [3:0]           opcode,
  input  logic [5:0]           func,
  input  logic                 bcond,
  output logic                 pc_write,
  output logic [1:0]           pc_src,
  output logic                 i_or_d,
  output logic                 mem_read,
  output logic                 mem_write,
  output logic                 ir_write,
  output logic                 reg_write,
  output logic [1:0]           reg_dst,
  output logic [1:0]           wb_sel,
  output logic                 alu_src_a,
  output logic [1:0]           alu_src_b,
  output logic [1:0]           alu_op,
  output logic                 output_en,
  output logic                 pvs_write_en,
  output logic [WORD_SIZE-1:0] num_inst,
  output logic                 is_halted,
  output logic [3:0]           dbg_state
);

  state_t                 state_q, state_d;
  logic [WORD_SIZE-1:0]   num_inst_q, num_inst_d;
  logic                   halt_seen_q, halt_seen_d;

  inst_class_t inst_class;
  logic        is_link, is_reg_jump, is_ori, is_rtype, is_load;

  mc_ctrl_decode u_decode (
    .opcode      (opcode),
    .func        (func),
    .inst_class  (inst_class),
    .is_link     (is_link),
    .is_reg_jump (is_reg_jump),
    .is_ori      (is_ori),
    .is_rtype    (is_rtype),
    .is_load     (is_load)
  );

  assign num_inst  = num_inst_q;
  assign dbg_state = state_q;

  // State, commit counter and halt-entry flag; reset aborts any instruction.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= S_RST;
      num_inst_q  <= '0;
      halt_seen_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      num_inst_q  <= num_inst_d;
      halt_seen_q <= halt_seen_d;
    end
  end

  // Next-state and Moore-decoded datapath controls (EX_BR pc_write follows bcond).
  always_comb begin
    state_d      = state_q;
    pc_write     = 1'b0;
    pc_src       = PC_SRC_ALU;
    i_or_d       = 1'b0;
    mem_read     = 1'b0;
    mem_write    = 1'b0;
    ir_write     = 1'b0;
    reg_write    = 1'b0;
    reg_dst      = REG_DST_RT;
    wb_sel       = WB_ALUOUT;
    alu_src_a    = ALU_A_PC;
    alu_src_b    = ALU_B_RT;
    alu_op       = ALU_OP_ADD;
    output_en    = 1'b0;
    pvs_write_en = 1'b0;
    is_halted    = 1'b0;
    halt_seen_d  = halt_seen_q;

    case (state_q)
      S_RST: state_d = S_IF;
      S_IF: begin
        i_or_d    = 1'b0;
        mem_read  = 1'b1;
        ir_write  = 1'b1;
        alu_src_a = ALU_A_PC;
        alu_src_b = ALU_B_ONE;
        alu_op    = ALU_OP_ADD;
        pc_write  = 1'b1;
        pc_src    = PC_SRC_ALU;
        state_d   = S_ID;
      end
      S_ID: begin
        // Branch target PC+sext(imm) is computed speculatively into ALUOut.
        alu_src_a = ALU_A_PC;
        alu_src_b = ALU_B_SEXT;
        alu_op    = ALU_OP_ADD;
        case (inst_class)
          CL_RALU: state_d = S_EX_R;
          CL_IALU: state_d = S_EX_I;
          CL_MEM:  state_d = S_EX_ADDR;
          CL_BR:   state_d = S_EX_BR;
          CL_JUMP: state_d = S_EX_J;
          CL_WWD:  state_d = S_EX_WWD;
          CL_HLT:  state_d = S_HALT;
          default: begin
            pvs_write_en = 1'b1;
            state_d      = S_IF;
          end
        endcase
      end
      S_EX_R: begin
        alu_src_a = ALU_A_RS;
        alu_src_b = ALU_B_RT;
        alu_op    = ALU_OP_RFUNC;
        state_d   = S_WB_ALU;
      end
      S_EX_I: begin
        alu_src_a = ALU_A_RS;
        alu_src_b = is_ori ? ALU_B_ZEXT : ALU_B_SEXT;
        alu_op    = ALU_OP_IFUNC;
        state_d   = S_WB_ALU;
      end
      S_WB_ALU: begin
        reg_write    = 1'b1;
        wb_sel       = WB_ALUOUT;
        reg_dst      = is_rtype ? REG_DST_RD : REG_DST_RT;
        pvs_write_en = 1'b1;
        state_d      = S_IF;
      end
      S_EX_ADDR: begin
        alu_src_a = ALU_A_RS;
        alu_src_b = ALU_B_SEXT;
        alu_op    = ALU_OP_ADD;
        state_d   = is_load ? S_MEM_RD : S_MEM_WR;
      end
      S_MEM_RD: begin
        i_or_d   = 1'b1;
        mem_read = 1'b1;
        state_d  = S_WB_MEM;
      end
      S_WB_MEM: begin
        reg_write    = 1'b1;
        wb_sel       = WB_MDR;
        reg_dst      = REG_DST_RT;
        pvs_write_en = 1'b1;
        state_d      = S_IF;
      end
      S_MEM_WR: begin
        i_or_d       = 1'b1;
        mem_write    = 1'b1;
        pvs_write_en = 1'b1;
        state_d      = S_IF;
      end
      S_EX_BR: begin
        alu_src_a    = ALU_A_RS;
        alu_src_b    = ALU_B_RT;
        alu_op       = ALU_OP_CMP;
        pc_src       = PC_SRC_ALUOUT;
        pc_write     = bcond;
        pvs_write_en = 1'b1;
        state_d      = S_IF;
      end
      S_EX_J: begin
        pc_write     = 1'b1;
        pc_src       = is_reg_jump ? PC_SRC_RS : PC_SRC_JTGT;
        if (is_link) begin
          reg_write = 1'b1;
          wb_sel    = WB_PC;
          reg_dst   = REG_DST_R2;
        end
        pvs_write_en = 1'b1;
        state_d      = S_IF;
      end
      S_EX_WWD: begin
        output_en    = 1'b1;
        pvs_write_en = 1'b1;
        state_d      = S_IF;
      end
      S_HALT: begin
        // Absorbing; the commit pulse fires only on the first HALT cycle.
        is_halted    = 1'b1;
        pvs_write_en = !halt_seen_q;
        halt_seen_d  = 1'b1;
        state_d      = S_HALT;
      end
      default: state_d = S_RST;
    endcase
  end

  // Commit counter; wraps naturally at the word boundary.
  always_comb begin
    num_inst_d = pvs_write_en ? num_inst_q + 16'd1 : num_inst_q;
  end

endmodule

// File: tb/tb_mc_control_fsm.sv
// Bench for mc_control_fsm: per-cycle expected control vectors from an
// instruction-level model, checked by an independent monitor.
module tb_mc_control_fsm;

  // Control fields of one cycle, in the order the monitor packs DUT outputs.
  typedef struct packed {
    logic       pcw;
    logic [1:0] pcs;
    logic       iod;
    logic       mr;
    logic       mw;
    logic       irw;
    logic       rw;
    logic [1:0] rd;
    logic [1:0] wb;
    logic       a;
    logic [1:0] b;
    logic [1:0] aop;
    logic       oe;
    logic       pvs;
    logic       hlt;
  } ctl_t;

  localparam int W = $bits(ctl_t) + 16;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [3:0]  opcode = 4'd0;
  logic [5:0]  func = 6'd0;
  logic        bcond = 1'b0;
  logic        pc_write, i_or_d, mem_read, mem_write, ir_write, reg_write;
  logic [1:0]  pc_src, reg_dst, wb_sel, alu_src_b, alu_op;
  logic        alu_src_a, output_en, pvs_write_en, is_halted;
  logic [15:0] num_inst;
  logic [3:0]  dbg_state;

  mc_control_fsm dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .opcode       (opcode),
    .func         (func),
    .bcond        (bcond),
    .pc_write     (pc_write),
    .pc_src       (pc_src),
    .i_or_d       (i_or_d),
    .mem_read     (mem_read),
    .mem_write    (mem_write),
    .ir_write     (ir_write),
    .reg_write    (reg_write),
    .reg_dst      (reg_dst),
    .wb_sel       (wb_sel),
    .alu_src_a    (alu_src_a),
    .alu_src_b    (alu_src_b),
    .alu_op       (alu_op),
    .output_en    (output_en),
    .pvs_write_en (pvs_write_en),
    .num_inst     (num_inst),
    .is_halted    (is_halted),
    .dbg_state    (dbg_state)
  );

  // Clock
  always #5 clk = ~clk;

  logic [W-1:0] exp_q[$];
  int           checks = 0;
  int           errors = 0;
  int           step = 0;
  bit           mon_en = 1'b0;
  logic [15:0]  model_count = 16'd0;

  function automatic ctl_t act_ctl();
    ctl_t c;
    c = {pc_write, pc_src, i_or_d, mem_read, mem_write, ir_write, reg_write,
         reg_dst, wb_sel, alu_src_a, alu_src_b, alu_op, output_en,
         pvs_write_en, is_halted};
    return c;
  endfunction

  // Monitor: one expected vector per cycle while the driver has work queued.
  always @(negedge clk) begin
    if (mon_en && reset_n && exp_q.size() > 0) begin
      logic [W-1:0] e;
      logic [W-1:0] a;
      e = exp_q.pop_front();
      a = {act_ctl(), num_inst};
      checks++;
      if (a !== e) begin
        errors++;
        $display("FAIL cycle_vec step=%0d ctl got=%05h exp=%05h num_inst got=%0d exp=%0d",
                 step, a[W-1:16], e[W-1:16], a[15:0], e[15:0]);
      end
      step++;
    end
  end

  // Scoreboard push: the count shown in a cycle is commits before that cycle.
  task automatic push(input ctl_t c);
    exp_q.push_back({c, model_count});
    if (c.pvs) model_count = model_count + 16'd1;
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Reference model: the cycle-by-cycle control pattern of one instruction.
  task automatic build(input logic [15:0] w, input logic bc, output int n);
    logic [3:0] op;
    logic [5:0] fn;
    ctl_t c;
    bit link;
    op = w[15:12];
    fn = w[5:0];
    n  = 0;
    // fetch: read instruction, PC <- PC + 1
    c = '0; c.mr = 1; c.irw = 1; c.b = 2'd1; c.pcw = 1;
    push(c); n++;
    // decode: ALUOut <- PC + sext(imm)
    c = '0; c.b = 2'd2;
    if (op == 4'd15 && fn > 6'd7 && !(fn inside {6'd25, 6'd26, 6'd28, 6'd29})) begin
      c.pvs = 1; push(c); n++; return;
    end
    if (op inside {4'd11, 4'd12, 4'd13, 4'd14}) begin
      c.pvs = 1; push(c); n++; return;
    end
    push(c); n++;
    c = '0;
    if (op == 4'd15 && fn <= 6'd7) begin
      c.a = 1; c.b = 2'd0; c.aop = 2'd2; push(c); n++;
      c = '0; c.rw = 1; c.rd = 2'd1; c.pvs = 1; push(c); n++;
    end else if (op >= 4'd4 && op <= 4'd6) begin
      c.a = 1; c.b = (op == 4'd5) ? 2'd3 : 2'd2; c.aop = 2'd3; push(c); n++;
      c = '0; c.rw = 1; c.pvs = 1; push(c); n++;
    end else if (op == 4'd7) begin
      c.a = 1; c.b = 2'd2; push(c); n++;
      c = '0; c.iod = 1; c.mr = 1; push(c); n++;
      c = '0; c.rw = 1; c.wb = 2'd1; c.pvs = 1; push(c); n++;
    end else if (op == 4'd8) begin
      c.a = 1; c.b = 2'd2; push(c); n++;
      c = '0; c.iod = 1; c.mw = 1; c.pvs = 1; push(c); n++;
    end else if (op <= 4'd3) begin
      c.a = 1; c.aop = 2'd1; c.pcs = 2'd1; c.pcw = bc; c.pvs = 1; push(c); n++;
    end else if (op == 4'd9 || op == 4'd10 || fn == 6'd25 || fn == 6'd26) begin
      link = (op == 4'd10) || (op == 4'd15 && fn == 6'd26);
      c.pcw = 1; c.pcs = (op == 4'd15) ? 2'd3 : 2'd2;
      if (link) begin c.rw = 1; c.wb = 2'd2; c.rd = 2'd2; end
      c.pvs = 1; push(c); n++;
    end else if (fn == 6'd28) begin
      c.oe = 1; c.pvs = 1; push(c); n++;
    end else begin
      c.hlt = 1; c.pvs = 1; push(c); n++;
    end
  endtask

  // Driver: present the instruction from the fetch cycle and run it out.
  task automatic issue(input logic [15:0] w, input logic bc);
    int n;
    build(w, bc, n);
    opcode = w[15:12];
    func   = w[5:0];
    bcond  = bc;
    tick(n);
  endtask

  // Release reset between edges; the RST cycle precedes the first fetch.
  task automatic release_reset();
    exp_q.delete();
    model_count = 16'd0;
    reset_n = 1'b1;
    push(ctl_t'(0));
    mon_en = 1'b1;
    tick(1);
  endtask

  task automatic check_direct(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", name, got, exp);
    end
  endtask

  initial begin
    logic [15:0] w;
    logic [3:0]  rop;
    logic [5:0]  rfn;
    int          n;

    // Reset state
    tick(3);
    check_direct("reset_ctl", 32'(act_ctl()), 32'd0);
    check_direct("reset_num_inst", 32'(num_inst), 32'd0);
    release_reset();

    // Directed instructions
    issue(16'hF1C0, 1'b0);   // ADD
    issue(16'h7105, 1'b0);   // LWD
    issue(16'h1234, 1'b0);   // BEQ not taken
    issue(16'h1234, 1'b1);   // BEQ taken
    issue(16'hA123, 1'b0);   // JAL
    issue(16'h9456, 1'b1);   // JMP
    issue(16'h5A0F, 1'b0);   // ORI
    issue(16'h4A0F, 1'b0);   // ADI
    issue(16'h8105, 1'b0);   // SWD
    issue(16'hF01C, 1'b0);   // WWD
    issue(16'hF01A, 1'b0);   // JRL
    issue(16'hF019, 1'b0);   // JPR
    issue(16'hB000, 1'b0);   // undefined opcode -> NOP
    issue(16'hF03F, 1'b0);   // undefined func -> NOP

    // Randomized instruction stream (HLT excluded until the end)
    for (int i = 0; i < 200; i++) begin
      rop = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 1) == 0) rfn = 6'($urandom_range(0, 63));
      else rfn = ($urandom_range(0, 2) == 0) ? 6'(25 + $urandom_range(0, 3)) : 6'($urandom_range(0, 7));
      if (rop == 4'd15 && rfn == 6'd29) rfn = 6'd28;
      w = {rop, 6'($urandom), rfn};
      issue(w, 1'($urandom_range(0, 1)));
    end

    // Reset asserted during MEM_WR aborts without commit
    build(16'h8207, 1'b0, n);
    void'(exp_q.pop_back());
    model_count = model_count - 16'd1;
    opcode = 4'd8;
    func   = 6'd7;
    tick(3);
    check_direct("memwr_active", 32'(mem_write), 32'd1);
    check_direct("memwr_pvs", 32'(pvs_write_en), 32'd1);
    mon_en  = 1'b0;
    reset_n = 1'b0;
    #1;
    check_direct("abort_mem_write", 32'(mem_write), 32'd0);
    check_direct("abort_pvs", 32'(pvs_write_en), 32'd0);
    check_direct("abort_num_inst", 32'(num_inst), 32'd0);
    tick(2);
    check_direct("abort_hold_num_inst", 32'(num_inst), 32'd0);
    release_reset();
    issue(16'hF2C1, 1'b0);   // R-type after re-reset
    issue(16'h8105, 1'b0);   // SWD completes this time

    // HLT then 20 idle cycles: count frozen, no further fetch
    build(16'hF01D, 1'b0, n);
    opcode = 4'hF;
    func   = 6'd29;
    for (int i = 0; i < 20; i++) begin
      ctl_t c;
      c = '0;
      c.hlt = 1;
      push(c);
    end
    tick(n + 20);
    check_direct("halt_num_inst", 32'(num_inst), 32'd3);
    check_direct("halt_flag", 32'(is_halted), 32'd1);

    // Drain
    n = 0;
    while (exp_q.size() > 0 && n < 50) begin
      tick(1);
      n++;
    end
    check_direct("drain_queue_empty", 32'(exp_q.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mc_control_fsm.md
# mc_control_fsm

Multi-cycle control sequencer for the 16-bit CPU. It decodes the latched opcode and function fields and steps the shared datapath through fetch, decode, execute, memory and write-back. The shared datapath is one ALU, one register file, a single memory port and the PC. It drives every datapath select and enable, commits one instruction per completed sequence, and counts committed instructions.

## Interface
- Parameters: none. Word size is the global `WORD_SIZE` (16).
- `clk` in 1: rising-edge clock.
- `reset_n` in 1: asynchronous, active-low reset.
- `opcode` in 4: instruction[15:12], valid from the cycle after `ir_write`.
- `func` in 6: instruction[5:0], valid from the cycle after `ir_write`.
- `bcond` in 1: branch-taken flag from the ALU compare, valid in EX_BR.
- `pc_write` out 1: PC load enable.
- `pc_src` out 2: PC source; 0=ALU result, 1=ALUOut reg, 2=jump target {pc[15:12],instr[11:0]}, 3=rs.
- `i_or_d` out 1: memory address select; 0=PC, 1=ALUOut.
- `mem_read` out 1: memory read strobe.
- `mem_write` out 1: memory write strobe.
- `ir_write` out 1: instruction register load.
- `reg_write` out 1: register file write enable.
- `reg_dst` out 2: destination select; 0=rt, 1=rd, 2=r2.
- `wb_sel` out 2: write-back source; 0=ALUOut, 1=MDR, 2=PC.
- `alu_src_a` out 1: ALU A source; 0=PC, 1=rs.
- `alu_src_b` out 2: ALU B source; 0=rt, 1=const 1, 2=sign-extended imm, 3=zero-extended imm.
- `alu_op` out 2: ALU operation; 0=add, 1=compare, 2=R-type by func, 3=I-type by opcode.
- `output_en` out 1: latches rs into output_port (WWD).
- `pvs_write_en` out 1: one-cycle commit pulse.
- `num_inst` out 16: committed-instruction count.
- `is_halted` out 1: high once HLT executes.

## Operation
- States: RST, IF, ID, EX_R, EX_I, EX_ADDR, MEM_RD, MEM_WR, WB_ALU, WB_MEM, EX_BR, EX_J, EX_WWD, HALT.
- Outputs are Moore-decoded from the state. `pc_write` in EX_BR is the one exception: it equals `bcond`.
- Every output is 0 in any state where it is not listed below.
- **RST** → IF. All outputs are 0.
- **IF** → ID.
  - Memory read: `i_or_d`=0, `mem_read`, `ir_write`.
  - PC increment: ALU computes PC+1 (a=0, b=1, op=0); `pc_write` with `pc_src`=0.
- **ID** → by class.
  - ALU computes PC+sext(imm) into ALUOut as the branch target.
  - R-ALU (opcode 15; func 0–7) → EX_R.
  - ADI/ORI/LHI (4/5/6) → EX_I.
  - LWD/SWD (7/8) → EX_ADDR.
  - BNE/BEQ/BGZ/BLZ (0–3) → EX_BR.
  - JMP/JAL (9/10), and JPR/JRL (opcode 15; func 25/26) → EX_J.
  - WWD (func 28) → EX_WWD.
  - HLT (func 29) → HALT.
  - Any other encoding commits as a NOP: `pvs_write_en` pulses here, next state is IF.
- **EX_R**: a=rs, b=rt, op=2 → WB_ALU.
- **EX_I**: a=rs, op=3; b=3 for ORI, otherwise b=2 → WB_ALU.
- **WB_ALU**: `reg_write`; `wb_sel`=0; `reg_dst`=1 for R-type, 0 for I-type; commit → IF.
- **EX_ADDR**: a=rs, b=2, op=0 → MEM_RD (LWD) or MEM_WR (SWD).
- **MEM_RD**: `i_or_d`=1, `mem_read` → WB_MEM.
- **WB_MEM**: `reg_write`, `wb_sel`=1, `reg_dst`=0; commit → IF.
- **MEM_WR**: `i_or_d`=1, `mem_write`; commit → IF.
- **EX_BR**: a=rs, b=rt, op=1; `pc_src`=1; `pc_write`=`bcond`; commit → IF.
- **EX_J**: `pc_write`; `pc_src`=2 for JMP/JAL, 3 for JPR/JRL; commit → IF.
  - JAL/JRL additionally assert `reg_write`, `wb_sel`=2, `reg_dst`=2.
- **EX_WWD**: `output_en`; commit → IF.
- **HALT**: absorbing. `is_halted`=1; `pvs_write_en` pulses on entry only. No further fetch or count.
- `num_inst` increments on every `pvs_write_en` and wraps 0xFFFF→0.

## Timing
- Reset values:
  - State = RST; `num_inst`=0; every output 0.
  - Reset asserted mid-instruction aborts it immediately, with no commit.
- First IF occurs on the 2nd rising edge after reset release.
- Cycles per instruction, IF through commit:
  - NOP 2.
  - Branch, jump and WWD 3.
  - R-type, I-type ALU and SWD 4.
  - LWD 5.
- Commit happens in the instruction's last cycle. `num_inst` shows the new value the cycle after.
- `mem_read` and `mem_write` are never asserted together. Each memory access lasts exactly one cycle.
- `opcode` and `func` are sampled from ID onward. They must hold until the next IF.

## Structure
- Package `mc_ctrl_pkg`:
  - State enum.
  - Opcode and func constants.
  - Encodings for `pc_src`, `reg_dst`, `wb_sel`, `alu_src_b` and `alu_op`.
- Sub-module `mc_ctrl_decode`: combinational opcode/func → instruction class, plus is_link/is_reg_jump flags. It is used by the ID next-state logic and the EX_J/EX_I output logic.

## Test plan
- ADD (0xF1C0) after reset: states IF, ID, EX_R, WB_ALU. `reg_write`=1 with `reg_dst`=1 in cycle 4. `num_inst` 0→1.
- LWD (0x7105): 5 cycles. MEM_RD shows `i_or_d`=1 and `mem_read`=1. WB_MEM shows `wb_sel`=1.
- BEQ with `bcond`=0 and then `bcond`=1: `pc_write` is 0 and 1 in EX_BR respectively. Both commit after 3 cycles.
- JAL (0xA123): EX_J shows `pc_src`=2, `reg_write`=1, `reg_dst`=2, `wb_sel`=2.
- HLT (0xF01D): `is_halted` stays 1. `num_inst` increments once and then stays frozen over 20 cycles.
- `reset_n` pulled low during MEM_WR: `mem_write` drops to 0 asynchronously, `num_inst` reads 0, and the first IF follows 2 edges after release.
